uart_tx_drain: RTL and testbench

Serial UART transmitter that drains bytes from the upstream byte FIFO and shifts them out on a single TX line, 8N1 by default.
- Sits directly downstream of the FIFO: reads the front byte, pops it, and serialises it LSB first.
- Respects the FIFO pop rules: no pop while empty, no pop while it was empty the previous cycle, no pops on consecutive cycles.

---
 rtl/uart_tx_drain.sv | 112 +++++++++++
 tb/tb_uart_tx_drain.sv | 192 +++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_drain.sv
// uart_tx_drain: 8N1 UART transmitter popping bytes from an upstream FIFO, LSB first.
// Define UART_TX_PARITY_EN to insert an even-parity bit between the data and stop bits.
module uart_tx_drain #(
    parameter int CLKS_PER_BIT = 104,
    parameter int STOP_BITS    = 1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       fifo_empty,
    input  logic [7:0] fifo_data,
    output logic       fifo_pop,
    output logic       tx,
    output logic       busy,
    output logic       frame_done
);
    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0] PRE = CW'(CLKS_PER_BIT - 2);
    localparam logic [2:0] STOP_LAST = 3'(STOP_BITS - 1);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
`ifdef UART_TX_PARITY_EN
        PARITY,
`endif
        STOP
    } state_t;

    state_t state;
    logic [CW-1:0] cnt;
    logic [2:0] idx;
    logic [7:0] shift;
    logic empty_q;
`ifdef UART_TX_PARITY_EN
    logic par;
`endif

    assign fifo_pop = (state == IDLE) && !rst && !fifo_empty && !empty_q;
    assign busy = (state != IDLE) || fifo_pop;

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            tx         <= 1'b1;
            frame_done <= 1'b0;
            cnt        <= '0;
            idx        <= '0;
            shift      <= '0;
            empty_q    <= 1'b1;
`ifdef UART_TX_PARITY_EN
            par        <= 1'b0;
`endif
        end else begin
            empty_q <= fifo_empty;
            // every state change happens at a bit boundary, so wrapping here also clears on change
            cnt <= (state == IDLE || cnt == LAST) ? '0 : cnt + 1'b1;
            // registered, so raised one cycle ahead of the final stop cycle
            frame_done <= (state == STOP) && (cnt == PRE) && (idx == STOP_LAST);
            case (state)
                IDLE: if (fifo_pop) begin
                    shift <= fifo_data;
                    state <= START;
                    tx    <= 1'b0;
                    idx   <= '0;
`ifdef UART_TX_PARITY_EN
                    par   <= ^fifo_data;
`endif
                end
                START: if (cnt == LAST) begin
                    state <= DATA;
                    tx    <= shift[0];
                end
                DATA: if (cnt == LAST) begin
                    shift <= shift >> 1;
                    if (idx == 3'd7) begin
                        idx <= '0;
`ifdef UART_TX_PARITY_EN
                        state <= PARITY;
                        tx    <= par;
`else
                        state <= STOP;
                        tx    <= 1'b1;
`endif
                    end else begin
                        idx <= idx + 3'd1;
                        tx  <= shift[1];
                    end
                end
`ifdef UART_TX_PARITY_EN
                PARITY: if (cnt == LAST) begin
                    state <= STOP;
                    tx    <= 1'b1;
                end
`endif
                STOP: if (cnt == LAST) begin
                    if (idx == STOP_LAST) begin
                        state <= IDLE;
                        idx   <= '0;
                    end else begin
                        idx <= idx + 3'd1;
                    end
                end
                default: begin
                    state <= IDLE;
                    tx    <= 1'b1;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_uart_tx_drain.sv
// tb_uart_tx_drain: scoreboard bench; a FIFO model feeds bytes, a monitor checks every tx cycle of each frame.
module tb_uart_tx_drain;
    localparam int CPB = 4;
`ifdef UART_TX_PARITY_EN
    localparam int NB = 11;
`else
    localparam int NB = 10;
`endif

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic fifo_empty;
    logic [7:0] fifo_data;
    logic fifo_pop, tx, busy, frame_done;

    int checks = 0;
    int failures = 0;
    logic [7:0] fq[$];
    logic [7:0] exp_q[$];

    uart_tx_drain #(.CLKS_PER_BIT(CPB), .STOP_BITS(1)) dut (
        .clk(clk), .rst(rst), .fifo_empty(fifo_empty), .fifo_data(fifo_data),
        .fifo_pop(fifo_pop), .tx(tx), .busy(busy), .frame_done(frame_done)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            failures++;
            $display("FAIL %s got=%0h want=%0h at %0t", name, got, want, $time);
        end
    endtask

    function automatic void upd();
        fifo_empty = (fq.size() == 0);
        fifo_data = (fq.size() != 0) ? fq[0] : 8'h00;
    endfunction

    task automatic push(input logic [7:0] b);
        fq.push_back(b);
        exp_q.push_back(b);
        upd();
    endtask

    task automatic wait_pop(input int max, output int n);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!fifo_pop && n < max);
        check("pop_seen", fifo_pop, 1);
    endtask

    task automatic wait_idle();
        int n = 0;
        while ((busy || fq.size() != 0) && n < 300) begin
            @(negedge clk);
            n++;
        end
        check("idle_timeout", n < 300, 1);
        repeat (2) @(negedge clk);
    endtask

    // FIFO model: consumes the front byte after a pop cycle
    initial begin
        logic p;
        upd();
        forever begin
            @(negedge clk);
            p = fifo_pop;
            @(posedge clk);
            #1;
            if (p && fq.size() != 0) void'(fq.pop_front());
            upd();
        end
    end

    // monitor: frame-by-frame tx check against the expected-byte queue
    initial begin
        logic [10:0] fr;
        logic [7:0] b;
        @(posedge clk);
        forever begin
            @(negedge clk);
            if (fifo_pop) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_pop", 1, 0);
                end else begin
                    b = exp_q.pop_front();
                    fr = '1;
                    fr[0] = 1'b0;
                    fr[8:1] = b;
`ifdef UART_TX_PARITY_EN
                    fr[9] = ^b;
`endif
                    for (int i = 0; i < NB * CPB; i++) begin
                        @(negedge clk);
                        if (rst) break;
                        check($sformatf("tx_%02h_bit%0d", b, i / CPB), tx, fr[i / CPB]);
                        check($sformatf("frame_done_%02h_c%0d", b, i), frame_done, i == NB * CPB - 1);
                        check("busy_in_frame", busy, 1);
                    end
                end
            end else begin
                check("idle_tx", tx, 1);
                check("idle_frame_done", frame_done, 0);
                check("idle_busy", busy, 0);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout want=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        // reset with a byte already waiting
        push(8'h3C);
        repeat (3) begin
            @(negedge clk);
            check("rst_tx", tx, 1);
            check("rst_pop", fifo_pop, 0);
            check("rst_busy", busy, 0);
        end
        @(posedge clk); #1 rst = 1'b0;
        @(negedge clk);
        check("post_rst_pop", fifo_pop, 0);
        @(negedge clk);
        check("post_rst_pop2", fifo_pop, 1);
        wait_idle();

        // single byte, wake timing from empty falling
        @(posedge clk); #1 push(8'hA5);
        @(negedge clk);
        check("wake_pop_early", fifo_pop, 0);
        @(negedge clk);
        check("wake_pop", fifo_pop, 1);
        wait_idle();

        // back-to-back frames
        @(posedge clk); #1;
        push(8'h00);
        push(8'hFF);
        wait_pop(10, n);
        wait_pop(60, n);
        check("pop_spacing", n, 41);
        wait_idle();

        // one-cycle empty glitch must not pop
        @(posedge clk); #1 fq.push_back(8'h99); upd();
        @(posedge clk); #1 fq.delete(); upd();
        repeat (6) begin
            @(negedge clk);
            check("glitch_pop", fifo_pop, 0);
            check("glitch_tx", tx, 1);
        end
        wait_idle();

        // reset during data bit 3
        @(posedge clk); #1 push(8'h0F);
        wait_pop(10, n);
        repeat (18) @(posedge clk);
        #1 rst = 1'b1;
        push(8'h5A);
        @(negedge clk);
        @(negedge clk);
        check("abort_tx", tx, 1);
        check("abort_busy", busy, 0);
        check("abort_frame_done", frame_done, 0);
        @(posedge clk); #1 rst = 1'b0;
        @(negedge clk);
        check("abort_repop_early", fifo_pop, 0);
        @(negedge clk);
        check("abort_repop", fifo_pop, 1);
        wait_idle();

        // parity-sensitive bytes
        @(posedge clk); #1;
        push(8'h07);
        push(8'h03);
        wait_idle();

        check("scoreboard_drain", exp_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
